serial_subtractor_ctrl: RTL and testbench

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_subtractor_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial subtractor (LSB first) wrapped in an IDLE/BUSY/DONE controller.
// One operand pair is latched per accepted start; WIDTH BUSY cycles produce
// one difference bit each, and a single DONE cycle presents the result.
// The d and c output registers are updated only on the last BUSY edge, so
// they stay stable while the next subtraction is in progress.
//
// Optional build macro: SERIAL_SUB_CLAMP_EN
//   When defined, a negative result (final borrow = 1) is clamped to d = 0;
//   c still reports the borrow. When undefined, d is the wrapped difference.

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             c
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the low WIDTH-1 result bits; the MSB joins them on the final cycle.
    logic [WIDTH-2:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             bflop;

    logic             a_i;
    logic             b_i;
    logic             d_bit;
    logic             bout;
    logic             last_bit;
    logic [WIDTH-1:0] r_full;

    // One full-subtractor slice: two cascaded half-subtractors, borrows OR-ed.
    always_comb begin
        a_i      = a_sh[0];
        b_i      = b_sh[0];
        d_bit    = a_i ^ b_i ^ bflop;
        bout     = (~a_i & b_i) | (~(a_i ^ b_i) & bflop);
        last_bit = (cnt == CW'(WIDTH - 1));
        r_full   = {d_bit, r_sh};
    end

    // State register; asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs; start is only looked at in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, shift one bit per BUSY cycle,
    // and publish d/c on the final BUSY edge so they are valid during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            bflop <= 1'b0;
            d     <= '0;
            c     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        r_sh  <= '0;
                        cnt   <= '0;
                        bflop <= 1'b0;
                    end
                end
                S_BUSY: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    bflop <= bout;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        c <= bout;
`ifdef SERIAL_SUB_CLAMP_EN
                        d <= bout ? '0 : r_full;
`else
                        d <= r_full;
`endif
                    end else begin
                        r_sh <= r_full[WIDTH-1:1];
                    end
                end
                default: begin
                    // DONE: hold everything; the controller returns to IDLE.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
// Directed checks of serial_subtractor_ctrl at WIDTH=8: reset values,
// single operations with latency/pulse checks, held-start back-to-back
// operation, and asynchronous reset mid-operation.
// Honours SERIAL_SUB_CLAMP_EN for the expected value of negative results.

module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             c;

    int n_vec;
    int n_miss;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected d for a result whose hand-computed wrapped value and borrow are given.
    function automatic logic [WIDTH-1:0] exp_d(input logic [WIDTH-1:0] wrapped, input logic borrow);
`ifdef SERIAL_SUB_CLAMP_EN
        return borrow ? '0 : wrapped;
`else
        return wrapped;
`endif
    endfunction

    // One operation from IDLE: start for one edge, scramble operands while
    // busy, then check busy length, latency, result, held outputs and pulse width.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [WIDTH-1:0] wrapped, input logic borrow);
        int               n;
        int               busy_cnt;
        int               d_moves;
        logic [WIDTH-1:0] d_prev;
        logic             c_prev;
        d_prev = d;
        c_prev = c;
        start  = 1'b1;
        a      = va;
        b      = vb;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        a        = ~va;
        b        = ~vb;
        n        = 0;
        busy_cnt = 0;
        d_moves  = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (d !== d_prev || c !== c_prev) d_moves++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, WIDTH);
        check({tag, " busy_cycles"}, busy_cnt, WIDTH);
        check({tag, " held_during_busy"}, d_moves, 0);
        check({tag, " d"}, d, exp_d(wrapped, borrow));
        check({tag, " c"}, c, borrow);
        check({tag, " busy_in_done"}, busy, 0);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
        check({tag, " d_hold"}, d, exp_d(wrapped, borrow));
    endtask

    logic [WIDTH-1:0] bb_a   [3];
    logic [WIDTH-1:0] bb_b   [3];
    logic [WIDTH-1:0] bb_d   [3];
    logic             bb_c   [3];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #1 rst = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst d", d, 0);
        check("rst c", c, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed single operations (hand-computed 8-bit results).
        run_op("5-3",     8'h05, 8'h03, 8'h02, 1'b0);
        run_op("3-5",     8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("00-FF",   8'h00, 8'hFF, 8'h01, 1'b1);
        run_op("FF-FF",   8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("00-00",   8'h00, 8'h00, 8'h00, 1'b0);
        run_op("A5-3C",   8'hA5, 8'h3C, 8'h69, 1'b0);
        run_op("80-01",   8'h80, 8'h01, 8'h7F, 1'b0);

        // Start held high with operands changing every cycle: only edges
        // 0, 10, 20 (IDLE) latch; done follows 8 edges after each.
        bb_a[0] = 8'h40; bb_b[0] = 8'h10; bb_d[0] = 8'h30; bb_c[0] = 1'b0;
        bb_a[1] = 8'h10; bb_b[1] = 8'h40; bb_d[1] = 8'hD0; bb_c[1] = 1'b1;
        bb_a[2] = 8'h81; bb_b[2] = 8'h7F; bb_d[2] = 8'h02; bb_c[2] = 1'b0;
        begin
            int dones;
            dones = 0;
            start = 1'b1;
            for (int e = 0; e < 30; e++) begin
                if (e % 10 == 0) begin
                    a = bb_a[e / 10];
                    b = bb_b[e / 10];
                end else begin
                    a = 8'hAA ^ 8'(e * 13);
                    b = 8'h55 ^ 8'(e * 7);
                end
                @(posedge clk);
                @(negedge clk);
                if (e % 10 == 8) begin
                    check($sformatf("b2b done e%0d", e), done, 1);
                    check($sformatf("b2b d e%0d", e), d, exp_d(bb_d[e / 10], bb_c[e / 10]));
                    check($sformatf("b2b c e%0d", e), c, bb_c[e / 10]);
                end
                if (done) dones++;
            end
            start = 1'b0;
            check("b2b done_count", dones, 3);
            @(negedge clk);
        end

        // Asynchronous reset in the 4th BUSY cycle; d holds a nonzero value first.
        run_op("7F-01", 8'h7F, 8'h01, 8'h7E, 1'b0);
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst d", d, 0);
        check("midrst c", c, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int stray;
            stray = 0;
            repeat (12) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            check("midrst no_done", stray, 0);
        end
        run_op("post_rst 9-4", 8'h09, 8'h04, 8'h05, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
